issue_arbiter: RTL and testbench
================================

Name: issue_arbiter

Overview:
- Issue-stage scheduler between the four execution queues (INT, LS, MULT, DIV) and the functional units.
- Each cycle it decides which ready queues may issue, so that the results of all issued instructions never collide on the single CDB.
- It keeps a CDB-slot reservation shift register, a busy counter for the non-pipelined divider and a round-robin pointer between INT and LS.
- It drives the CDB result mux select and valid.

Parameters:
- LAT_INT, 1: issue-to-CDB latency of the integer unit, in cycles.
- LAT_LS, 1: issue-to-CDB latency of the load/store unit.
- LAT_MULT, 4: latency of the multiplier (fully pipelined).
- LAT_DIV, 7: latency of the divider (not pipelined).
- W_RSV, 8: reservation register depth; must be at least LAT_DIV+1. Constraint: LAT_MULT, LAT_DIV and 1 are pairwise distinct.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- issueint_ready  in  1  INT queue holds a ready instruction
- issuels_ready  in  1  LS queue holds a ready instruction
- issuemult_ready  in  1  MULT queue holds a ready instruction
- issuediv_ready  in  1  DIV queue holds a ready instruction
- issueint_en  out  1  grant; INT queue issues this cycle
- issuels_en  out  1  grant; LS queue issues this cycle
- issuemult_en  out  1  grant; MULT queue issues this cycle
- issuediv_en  out  1  grant; DIV queue issues this cycle
- cdb_sel  out  2  unit owning the CDB this cycle (0 INT, 1 LS, 2 MULT, 3 DIV)
- cdb_sel_valid  out  1  a result is scheduled on the CDB this cycle
- div_busy  out  1  divider occupied (debug/status)

Behaviour:
- State:
  - rsv[W_RSV-1:0]: bit i set means the CDB is booked i cycles from now. Bit 0 is the current cycle.
  - owner[W_RSV-1:0][1:0]: unit index for each booked slot.
  - div_cnt: counter, 3 bits minimum.
  - rr_ls: 0 means INT has priority, 1 means LS has priority.
- Grants are combinational from the ready inputs and the current state (same-cycle handshake). The queue issues in any cycle where its ready and en are both high.
- Grant conditions:
  - MULT: issuemult_ready and rsv[LAT_MULT]==0.
  - DIV: issuediv_ready and rsv[LAT_DIV]==0 and div_cnt==0.
  - INT and LS share slot LAT_INT==LAT_LS, and at most one of them is granted. Each is eligible when its ready is high and rsv[1]==0. If both are eligible, the one selected by rr_ls wins.
- Grants with distinct latencies are independent. Up to three grants (one of INT/LS, MULT, DIV) can occur in the same cycle.
- Update every cycle:
  - rsv_n = rsv>>1, then set bit L-1 for each grant with latency L. owner shifts in parallel and is written with the same indices.
  - div_cnt loads LAT_DIV-1 on a DIV grant, else decrements while nonzero. The next DIV grant comes no earlier than t+LAT_DIV.
  - rr_ls toggles to the other requester whenever INT or LS is granted; it is unchanged otherwise.
- Outputs: cdb_sel_valid = rsv[0]; cdb_sel = owner[0] (0 when invalid); div_busy = (div_cnt!=0).
- Reset, including mid-operation: in the next cycle rsv=0, owner=0, div_cnt=0, rr_ls=0. All grants are forced to 0 while reset is high. cdb_sel_valid=0 and cdb_sel=0 from the first cycle after reset. In-flight results are discarded; the execution units are reset by the same signal.
- Boundaries:
  - A ready held with no free slot waits; there is no timeout and no starvation between INT and LS.
  - A MULT result landing on the same cycle that an INT would land blocks the INT; the earlier booking always wins.
  - The reservation register never wraps: the maximum booking index is LAT_DIV-1 < W_RSV.

Decomposition:
- globals.vh gains:
  - unit index constants ISSUE_UNIT_INT=0, LS=1, MULT=2, DIV=3;
  - the latency constants LAT_*.
- One natural sub-module, cdb_slot_reserve: the rsv/owner shift register with multi-write booking ports and a slot-free query. The arbiter top holds the grant logic, div_cnt and rr_ls.

Test Plan:
- After reset, only issueint_ready=1 at t0 -> issueint_en=1 at t0; at t1 cdb_sel_valid=1, cdb_sel=0.
- issueint_ready and issuels_ready held high for 4 cycles -> grants INT, LS, INT, LS. cdb_sel sequence is 0,1,0,1 starting one cycle later.
- MULT ready at t0 and INT ready at t3 -> mult_en at t0, int_en blocked at t3 and granted at t4. CDB sel=2 at t4, sel=0 at t5.
- issuediv_ready held high -> div_en at t0, t7 and t14. div_busy=1 during t1..t6. cdb_sel=3 with valid at t7 and t14.
- INT, MULT and DIV all ready at t0 on an idle arbiter -> all three en=1 at t0. CDB valid at t1 (sel 0), t4 (sel 2) and t7 (sel 3).
- MULT granted at t0 and reset asserted at t2 for one cycle -> no grants at t2; cdb_sel_valid=0 at t3..t4; div_busy=0 and rr_ls back to INT priority.

Source files
------------

// File: rtl/issue_arbiter_pkg.sv
// Shared constants for the issue arbiter: unit indices used on the CDB select
// and the default issue-to-CDB latencies of each functional unit.
package issue_arbiter_pkg;

    localparam int UNIT_W = 2;

    typedef enum logic [UNIT_W-1:0] {
        ISSUE_UNIT_INT  = 2'd0,
        ISSUE_UNIT_LS   = 2'd1,
        ISSUE_UNIT_MULT = 2'd2,
        ISSUE_UNIT_DIV  = 2'd3
    } unit_t;

    localparam int LAT_INT_DEF  = 1;
    localparam int LAT_LS_DEF   = 1;
    localparam int LAT_MULT_DEF = 4;
    localparam int LAT_DIV_DEF  = 7;
    localparam int W_RSV_DEF    = 8;

endpackage

// File: rtl/issue_arbiter_cdb_slot_reserve.sv
// CDB slot reservation shift register: bit i means the bus is booked i cycles
// from now; owner tracks which unit holds each booked slot.
module issue_arbiter_cdb_slot_reserve
    import issue_arbiter_pkg::*;
#(
    parameter int W_RSV = W_RSV_DEF,
    parameter int IDX_W = $clog2(W_RSV)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    book_en,
    input  logic [2:0][IDX_W-1:0]         book_idx,
    input  logic [2:0][UNIT_W-1:0]        book_unit,
    input  logic [3:0][IDX_W-1:0]         query_idx,
    output logic [3:0]                    query_free,
    output logic                          valid_now,
    output logic [UNIT_W-1:0]             owner_now
);

    logic [W_RSV-1:0]             rsv;
    logic [W_RSV-1:0]             rsv_n;
    logic [W_RSV-1:0][UNIT_W-1:0] owner;
    logic [W_RSV-1:0][UNIT_W-1:0] owner_n;

    // Bookings are written after the shift, so index L-1 lands on slot L-1
    // of the next cycle, i.e. L cycles after the granting cycle.
    always_comb begin
        rsv_n   = {1'b0, rsv[W_RSV-1:1]};
        owner_n = {{UNIT_W{1'b0}}, owner[W_RSV-1:1]};
        for (int k = 0; k < 3; k++) begin
            if (book_en[k]) begin
                rsv_n[book_idx[k]]   = 1'b1;
                owner_n[book_idx[k]] = book_unit[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsv   <= '0;
            owner <= '0;
        end else begin
            rsv   <= rsv_n;
            owner <= owner_n;
        end
    end

    always_comb begin
        for (int q = 0; q < 4; q++) begin
            query_free[q] = ~rsv[query_idx[q]];
        end
    end

    assign valid_now = rsv[0];
    assign owner_now = rsv[0] ? owner[0] : '0;

endmodule

// File: rtl/issue_arbiter.sv
// Issue-stage scheduler: grants ready queues only when their result slot on
// the single CDB is free, serialises the divider and alternates INT/LS.
module issue_arbiter
    import issue_arbiter_pkg::*;
#(
    parameter int LAT_INT  = LAT_INT_DEF,
    parameter int LAT_LS   = LAT_LS_DEF,
    parameter int LAT_MULT = LAT_MULT_DEF,
    parameter int LAT_DIV  = LAT_DIV_DEF,
    parameter int W_RSV    = W_RSV_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issueint_ready,
    input  logic       issuels_ready,
    input  logic       issuemult_ready,
    input  logic       issuediv_ready,
    output logic       issueint_en,
    output logic       issuels_en,
    output logic       issuemult_en,
    output logic       issuediv_en,
    output logic [1:0] cdb_sel,
    output logic       cdb_sel_valid,
    output logic       div_busy
);

    localparam int IDX_W = $clog2(W_RSV);
    localparam int CNT_W = ($clog2(LAT_DIV) > 3) ? $clog2(LAT_DIV) : 3;

    logic [CNT_W-1:0]          div_cnt;
    logic                      rr_ls;
    logic [3:0]                query_free;
    logic                      int_elig;
    logic                      ls_elig;
    logic [2:0]                book_en;
    logic [2:0][IDX_W-1:0]     book_idx;
    logic [2:0][UNIT_W-1:0]    book_unit;
    logic [3:0][IDX_W-1:0]     query_idx;

    assign query_idx[0] = IDX_W'(LAT_INT);
    assign query_idx[1] = IDX_W'(LAT_LS);
    assign query_idx[2] = IDX_W'(LAT_MULT);
    assign query_idx[3] = IDX_W'(LAT_DIV);

    assign int_elig = issueint_ready & query_free[0];
    assign ls_elig  = issuels_ready  & query_free[1];

    // INT and LS land on the same slot, so only one may win; rr_ls breaks ties.
    assign issueint_en  = ~reset & int_elig & (~ls_elig | ~rr_ls);
    assign issuels_en   = ~reset & ls_elig  & (~int_elig | rr_ls);
    assign issuemult_en = ~reset & issuemult_ready & query_free[2];
    assign issuediv_en  = ~reset & issuediv_ready & query_free[3] & (div_cnt == '0);

    assign book_en[0]   = issueint_en | issuels_en;
    assign book_idx[0]  = IDX_W'(LAT_INT - 1);
    assign book_unit[0] = issueint_en ? ISSUE_UNIT_INT : ISSUE_UNIT_LS;
    assign book_en[1]   = issuemult_en;
    assign book_idx[1]  = IDX_W'(LAT_MULT - 1);
    assign book_unit[1] = ISSUE_UNIT_MULT;
    assign book_en[2]   = issuediv_en;
    assign book_idx[2]  = IDX_W'(LAT_DIV - 1);
    assign book_unit[2] = ISSUE_UNIT_DIV;

    issue_arbiter_cdb_slot_reserve #(
        .W_RSV (W_RSV),
        .IDX_W (IDX_W)
    ) u_rsv (
        .clk        (clk),
        .reset      (reset),
        .book_en    (book_en),
        .book_idx   (book_idx),
        .book_unit  (book_unit),
        .query_idx  (query_idx),
        .query_free (query_free),
        .valid_now  (cdb_sel_valid),
        .owner_now  (cdb_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            rr_ls   <= 1'b0;
        end else begin
            if (issuediv_en) begin
                div_cnt <= CNT_W'(LAT_DIV - 1);
            end else if (div_cnt != '0) begin
                div_cnt <= div_cnt - 1'b1;
            end
            if (issueint_en) begin
                rr_ls <= 1'b1;
            end else if (issuels_en) begin
                rr_ls <= 1'b0;
            end
        end
    end

    assign div_busy = (div_cnt != '0);

endmodule

// File: tb/tb_issue_arbiter.sv
// Directed and randomized bench for issue_arbiter against a reference model
// that books absolute CDB cycles in an associative array.
module tb_issue_arbiter;

    localparam int LAT_INT  = 1;
    localparam int LAT_LS   = 1;
    localparam int LAT_MULT = 4;
    localparam int LAT_DIV  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       issueint_ready, issuels_ready, issuemult_ready, issuediv_ready;
    logic       issueint_en, issuels_en, issuemult_en, issuediv_en;
    logic [1:0] cdb_sel;
    logic       cdb_sel_valid;
    logic       div_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state, in absolute cycle numbers.
    int cyc;
    int book[int];
    int div_free_at;
    bit rr_ls_prio;

    always #5 clk = ~clk;

    issue_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .issueint_ready  (issueint_ready),
        .issuels_ready   (issuels_ready),
        .issuemult_ready (issuemult_ready),
        .issuediv_ready  (issuediv_ready),
        .issueint_en     (issueint_en),
        .issuels_en      (issuels_en),
        .issuemult_en    (issuemult_en),
        .issuediv_en     (issuediv_en),
        .cdb_sel         (cdb_sel),
        .cdb_sel_valid   (cdb_sel_valid),
        .div_busy        (div_busy)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called just after a rising edge: apply inputs and let them settle.
    task automatic drive(input bit ri, input bit rl, input bit rm, input bit rd, input bit rst);
        issueint_ready  = ri;
        issuels_ready   = rl;
        issuemult_ready = rm;
        issuediv_ready  = rd;
        reset           = rst;
        #2;
    endtask

    // Compare every output against the model for the current cycle, update
    // the model and move to the next cycle.
    task automatic advance();
        bit e_int, e_ls, g_int, g_ls, g_mult, g_div, exp_valid;
        int exp_sel;
        exp_valid = book.exists(cyc);
        exp_sel   = exp_valid ? book[cyc] : 0;
        e_int  = issueint_ready && !book.exists(cyc + LAT_INT);
        e_ls   = issuels_ready  && !book.exists(cyc + LAT_LS);
        g_int  = e_int && !(e_ls && rr_ls_prio);
        g_ls   = e_ls  && !(e_int && !rr_ls_prio);
        g_mult = issuemult_ready && !book.exists(cyc + LAT_MULT);
        g_div  = issuediv_ready && !book.exists(cyc + LAT_DIV) && (cyc >= div_free_at);
        if (reset) begin
            g_int = 0; g_ls = 0; g_mult = 0; g_div = 0;
        end
        chk("int_en",  {3'b0, issueint_en},  {3'b0, g_int});
        chk("ls_en",   {3'b0, issuels_en},   {3'b0, g_ls});
        chk("mult_en", {3'b0, issuemult_en}, {3'b0, g_mult});
        chk("div_en",  {3'b0, issuediv_en},  {3'b0, g_div});
        chk("cdb_valid", {3'b0, cdb_sel_valid}, {3'b0, exp_valid});
        chk("cdb_sel", {2'b0, cdb_sel}, 4'(exp_sel));
        chk("div_busy", {3'b0, div_busy}, {3'b0, (cyc < div_free_at)});
        if (reset) begin
            book.delete();
            div_free_at = cyc + 1;
            rr_ls_prio  = 0;
        end else begin
            if (g_int)  book[cyc + LAT_INT]  = 0;
            if (g_ls)   book[cyc + LAT_LS]   = 1;
            if (g_mult) book[cyc + LAT_MULT] = 2;
            if (g_div) begin
                book[cyc + LAT_DIV] = 3;
                div_free_at = cyc + LAT_DIV;
            end
            if (g_int) rr_ls_prio = 1;
            else if (g_ls) rr_ls_prio = 0;
            if (book.exists(cyc)) book.delete(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        drive(1, 1, 1, 1, 1);
        advance();
    endtask

    initial begin
        // Bring the DUT out of its unknown power-up state before checking.
        issueint_ready = 0; issuels_ready = 0; issuemult_ready = 0; issuediv_ready = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        cyc = 0; div_free_at = 0; rr_ls_prio = 0;
        do_reset();
        drive(1, 1, 1, 1, 1);
        chk("rst_grants", {issueint_en, issuels_en, issuemult_en, issuediv_en}, 4'h0);
        chk("rst_valid", {3'b0, cdb_sel_valid}, 4'h0);
        advance();

        // Lone INT request, result one cycle later.
        do_reset();
        drive(1, 0, 0, 0, 0);
        chk("t1_int_en", {3'b0, issueint_en}, 4'h1);
        advance();
        drive(0, 0, 0, 0, 0);
        chk("t1_valid", {3'b0, cdb_sel_valid}, 4'h1);
        chk("t1_sel", {2'b0, cdb_sel}, 4'h0);
        advance();

        // INT and LS contending alternate.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(1, 1, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0);
            if (i < 4) begin
                chk("t2_int_en", {3'b0, issueint_en}, (i % 2 == 0) ? 4'h1 : 4'h0);
                chk("t2_ls_en",  {3'b0, issuels_en},  (i % 2 == 1) ? 4'h1 : 4'h0);
            end
            if (i > 0) chk("t2_sel", {2'b0, cdb_sel}, (i % 2 == 1) ? 4'h0 : 4'h1);
            advance();
        end

        // Earlier MULT booking blocks a later INT on the same landing cycle.
        do_reset();
        drive(0, 0, 1, 0, 0);
        chk("t3_mult_en", {3'b0, issuemult_en}, 4'h1);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            advance();
        end
        drive(1, 0, 0, 0, 0);
        chk("t3_int_blocked", {3'b0, issueint_en}, 4'h0);
        advance();
        drive(1, 0, 0, 0, 0);
        chk("t3_int_late", {3'b0, issueint_en}, 4'h1);
        chk("t3_sel_mult", {cdb_sel_valid, 1'b0, cdb_sel}, 4'hA);
        advance();
        drive(0, 0, 0, 0, 0);
        chk("t3_sel_int", {cdb_sel_valid, 1'b0, cdb_sel}, 4'h8);
        advance();

        // Divider held ready issues every LAT_DIV cycles.
        do_reset();
        for (int t = 0; t < 15; t++) begin
            drive(0, 0, 0, 1, 0);
            chk("t4_div_en", {3'b0, issuediv_en}, (t % 7 == 0) ? 4'h1 : 4'h0);
            chk("t4_busy", {3'b0, div_busy}, (t % 7 != 0) ? 4'h1 : 4'h0);
            if (t == 7 || t == 14) chk("t4_sel_div", {cdb_sel_valid, 1'b0, cdb_sel}, 4'hB);
            advance();
        end

        // INT, MULT and DIV together on an idle arbiter.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            if (t == 0) drive(1, 0, 1, 1, 0);
            else        drive(0, 0, 0, 0, 0);
            if (t == 0) chk("t5_grants", {issueint_en, issuels_en, issuemult_en, issuediv_en}, 4'hB);
            if (t == 1) chk("t5_cdb1", {cdb_sel_valid, 1'b0, cdb_sel}, 4'h8);
            if (t == 4) chk("t5_cdb4", {cdb_sel_valid, 1'b0, cdb_sel}, 4'hA);
            if (t == 7) chk("t5_cdb7", {cdb_sel_valid, 1'b0, cdb_sel}, 4'hB);
            advance();
        end

        // Mid-operation reset discards the in-flight MULT result.
        do_reset();
        drive(1, 0, 1, 1, 0);
        advance();
        drive(0, 0, 0, 0, 0);
        advance();
        drive(1, 1, 1, 1, 1);
        chk("t6_no_grants", {issueint_en, issuels_en, issuemult_en, issuediv_en}, 4'h0);
        advance();
        for (int t = 3; t < 5; t++) begin
            drive(0, 0, 0, 0, 0);
            chk("t6_valid", {3'b0, cdb_sel_valid}, 4'h0);
            chk("t6_busy", {3'b0, div_busy}, 4'h0);
            advance();
        end
        drive(1, 1, 0, 0, 0);
        chk("t6_rr_int", {issueint_en, issuels_en}, 4'h2);
        advance();

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 59) == 0);
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
